// File: rtl/count_sequencer.sv
// count_sequencer: commanded-run controller for a WIDTH-bit up/down counter.
// A start in IDLE captures a preload value, direction and mode into shadow
// registers. The count then steps once per clock until it reaches the terminal
// value, which is 0 when counting down and all-ones when counting up. At that
// point the run either ends with a done pulse (one-shot) or reloads the shadow
// value and keeps running (auto-reload). Pause holds the count, and abort ends
// the run without a done pulse.
module count_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] load_q, load_d;  // shadow preload value
  logic             dir_q, dir_d;    // shadow direction
  logic             mode_q, mode_d;  // shadow mode

  logic [WIDTH-1:0] term_val;
  logic             at_term;

  // Terminal value follows the captured direction, not the live dir input.
  always_comb begin
    term_val = dir_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    at_term  = (q_q == term_val);
  end

  // Next-state logic. Priority inside a run: abort, then pause, then terminal, then step.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so that no path through
    // the case statement leaves it unassigned; otherwise a latch would be inferred.
    state_d = state_q;
    q_d     = q_q;
    load_d  = load_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_d  = load_val;
          dir_d   = dir;
          mode_d  = mode;
          q_d     = load_val;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pause) begin
          // The terminal check is skipped this cycle and is seen again after resume.
          state_d = S_PAUSED;
        end else if (at_term) begin
          done_d = 1'b1;
          if (mode_q) begin
            q_d = load_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          q_d = dir_q ? (q_q + 1'b1) : (q_q - 1'b1);
        end
      end

      S_PAUSED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // busy is registered, so it must reflect the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the values from before the edge, independent of statement order.
    if (!reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tc   = (state_q == S_RUN) && at_term;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed testbench for count_sequencer (WIDTH = 3).
// Inputs change 1 time unit after each rising edge, and outputs are sampled at
// the same point. Expected values are worked out by hand from the behaviour.
module tb_count_sequencer;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             mode;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             done;
  logic             tc;

  int checks = 0;
  int errors = 0;

  count_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .pause    (pause),
    .abort    (abort),
    .Q        (Q),
    .busy     (busy),
    .done     (done),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all four outputs against the expected values.
  task automatic expect_out(input string tag, input logic [7:0] e_q, input logic e_busy,
                            input logic e_done, input logic e_tc);
    check({tag, ".Q"},    {5'd0, Q},    e_q);
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, e_busy});
    check({tag, ".done"}, {7'd0, done}, {7'd0, e_done});
    check({tag, ".tc"},   {7'd0, tc},   {7'd0, e_tc});
  endtask

  task automatic issue_start(input logic [WIDTH-1:0] l, input logic d, input logic m);
    start    = 1'b1;
    load_val = l;
    dir      = d;
    mode     = m;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; load_val = '0; dir = 1'b0; mode = 1'b0;
    pause = 1'b0; abort = 1'b0;
    #1;

    // Power-on reset.
    step(); step();
    expect_out("por", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    expect_out("idle_hold", 8'd0, 1'b0, 1'b0, 1'b0);

    // One-shot down run from 5.
    issue_start(3'd5, 1'b0, 1'b0);
    step();
    start = 1'b0;
    expect_out("down_load", 8'd5, 1'b1, 1'b0, 1'b0);
    for (int v = 4; v >= 0; v--) begin
      step();
      expect_out($sformatf("down_q%0d", v), 8'(v), 1'b1, 1'b0, (v == 0));
    end
    step();
    expect_out("down_done", 8'd0, 1'b0, 1'b1, 1'b0);
    step();
    expect_out("down_after", 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run at Q=4, with start held high during reset.
    issue_start(3'd5, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    expect_out("rst_pre", 8'd4, 1'b1, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b1;
    step();
    expect_out("rst_mid", 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("rst_start_ign", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; start = 1'b0;
    step();
    expect_out("rst_release", 8'd0, 1'b0, 1'b0, 1'b0);

    // Auto-reload up run from 6: 6,7,6,7,...
    issue_start(3'd6, 1'b1, 1'b1);
    step();
    start = 1'b0;
    expect_out("up_load", 8'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out($sformatf("up_top%0d", i), 8'd7, 1'b1, 1'b0, 1'b1);
      step();
      expect_out($sformatf("up_reload%0d", i), 8'd6, 1'b1, 1'b1, 1'b0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_out("up_abort", 8'd6, 1'b0, 1'b0, 1'b0);

    // Down run from 5 with pause held for two edges while Q=3.
    issue_start(3'd5, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step(); step();
    expect_out("pz_pre", 8'd3, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    step();
    expect_out("pz_enter", 8'd3, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("pz_hold", 8'd3, 1'b1, 1'b0, 1'b0);
    pause = 1'b0;
    step();
    expect_out("pz_resume", 8'd3, 1'b1, 1'b0, 1'b0);
    for (int v = 2; v >= 0; v--) begin
      step();
      expect_out($sformatf("pz_q%0d", v), 8'(v), 1'b1, 1'b0, (v == 0));
    end
    step();
    expect_out("pz_done", 8'd0, 1'b0, 1'b1, 1'b0);

    // Pause and terminal in the same cycle: pause wins, done only after resume.
    issue_start(3'd1, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    expect_out("pt_term", 8'd0, 1'b1, 1'b0, 1'b1);
    pause = 1'b1;
    step();
    pause = 1'b0;
    expect_out("pt_paused", 8'd0, 1'b1, 1'b0, 1'b0);
    step();
    expect_out("pt_resume", 8'd0, 1'b1, 1'b0, 1'b1);
    step();
    expect_out("pt_done", 8'd0, 1'b0, 1'b1, 1'b0);

    // Auto-reload down from 5; a start mid-run must not disturb the shadow value.
    issue_start(3'd5, 1'b0, 1'b1);
    step();
    start = 1'b0;
    step(); step();
    expect_out("ar_q3", 8'd3, 1'b1, 1'b0, 1'b0);
    issue_start(3'd1, 1'b1, 1'b0);
    step();
    start = 1'b0;
    expect_out("ar_start_ign", 8'd2, 1'b1, 1'b0, 1'b0);
    step(); step();
    expect_out("ar_term", 8'd0, 1'b1, 1'b0, 1'b1);
    step();
    expect_out("ar_reload", 8'd5, 1'b1, 1'b1, 1'b0);
    step(); step(); step();
    expect_out("ar_q2", 8'd2, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_out("ar_abort", 8'd2, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_out("idle_abort", 8'd2, 1'b0, 1'b0, 1'b0);

    // Preload equal to terminal, one-shot: done one edge after start.
    issue_start(3'd0, 1'b0, 1'b0);
    step();
    start = 1'b0;
    expect_out("lt_load", 8'd0, 1'b1, 1'b0, 1'b1);
    step();
    expect_out("lt_done", 8'd0, 1'b0, 1'b1, 1'b0);

    // Same, with abort arriving on the terminal cycle: no done.
    issue_start(3'd0, 1'b0, 1'b0);
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_out("lt_abort", 8'd0, 1'b0, 1'b0, 1'b0);

    // Preload equal to terminal, auto-reload up: done pulses every RUN cycle.
    issue_start(3'd7, 1'b1, 1'b1);
    step();
    start = 1'b0;
    expect_out("lr_load", 8'd7, 1'b1, 1'b0, 1'b1);
    step();
    expect_out("lr_pulse0", 8'd7, 1'b1, 1'b1, 1'b1);
    step();
    expect_out("lr_pulse1", 8'd7, 1'b1, 1'b1, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    expect_out("lr_abort", 8'd7, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
